// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  localparam int DEF_LATENCY = 2;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;

  // Wide enough to hold LATENCY-1 for latencies 1..15.
  localparam int CNT_W = 4;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag; paces each access through BUSY.
module mem_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (dec && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and DM ports onto a single-ported word memory with a fixed
// multi-cycle access latency. Define ARB_ROUND_ROBIN_EN for round-robin grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              halt,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_createdump
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  arb_state_e        state, state_nxt;
  logic              cnt_zero, access, busy;
  logic              if_ok, dm_ok, grant_if, grant_dm;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wr;
  logic [DATA_W-1:0] lat_wdata;

  // A port is never re-granted during its own done cycle.
  assign if_ok  = if_req & ~if_done;
  assign dm_ok  = dm_req & ~dm_done;
  assign busy   = (state == BUSY_IF) || (state == BUSY_DM);
  assign access = busy & cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == IDLE) begin
      if (if_ok && dm_ok) begin
        grant_dm = (last_grant == PORT_IF);
        grant_if = (last_grant == PORT_DM);
      end else begin
        grant_dm = dm_ok;
        grant_if = if_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= PORT_IF;
    else if (grant_dm)
      last_grant <= PORT_DM;
    else if (grant_if)
      last_grant <= PORT_IF;
  end
`else
  always_comb begin
    grant_dm = (state == IDLE) && dm_ok;
    grant_if = (state == IDLE) && if_ok && !dm_ok;
  end
`endif

  mem_lat_counter #(.W(CNT_W)) u_lat_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (grant_if | grant_dm),
    .value (LOAD_VAL),
    .dec   (busy),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm)
          state_nxt = BUSY_DM;
        else if (grant_if)
          state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_DM: begin
        if (cnt_zero)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes are masked during rst so the memory's image load is undisturbed.
  always_comb begin
    mem_enable     = access & ~rst;
    mem_wr         = mem_enable & lat_wr;
    mem_addr       = mem_enable ? lat_addr : '0;
    mem_data_in    = mem_enable ? lat_wdata : '0;
    mem_createdump = halt & (state == IDLE) & ~rst;
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (grant_dm) begin
        lat_addr  <= dm_addr;
        lat_wr    <= dm_wr;
        lat_wdata <= dm_wdata;
      end else if (grant_if) begin
        lat_addr  <= if_addr;
        lat_wr    <= 1'b0;
        lat_wdata <= '0;
      end
      if_done <= access && (state == BUSY_IF);
      dm_done <= access && (state == BUSY_DM);
      if (access && state == BUSY_IF)
        if_rdata <= mem_data_out;
      if (access && state == BUSY_DM && !lat_wr)
        dm_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (LATENCY=2) driving a behavioural
// word memory; directed vectors, corner sequences and a randomized model run.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int NCYC = 600;

  typedef struct {
    bit          is_dm;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_wr, halt;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_stall, if_done, dm_stall, dm_done;
  logic [15:0] if_rdata, dm_rdata;
  logic        mem_enable, mem_wr, mem_createdump;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;

  logic [15:0] mem    [0:65535];
  logic [15:0] shadow [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr, bd_data;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[8];

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_stall       (if_stall),
    .if_done        (if_done),
    .if_rdata       (if_rdata),
    .dm_req         (dm_req),
    .dm_wr          (dm_wr),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_stall       (dm_stall),
    .dm_done        (dm_done),
    .dm_rdata       (dm_rdata),
    .halt           (halt),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_createdump (mem_createdump)
  );

  // Behavioural single-ported memory with a backdoor for preloading.
  always @(posedge clk) begin
    if (bd_we)
      mem[bd_addr] <= bd_data;
    else if (mem_enable && mem_wr)
      mem[mem_addr] <= mem_data_in;
  end
  assign mem_data_out = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    tick();
    bd_we   = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0)
      return 16'hFFFF;
    return 16'($urandom_range(0, 7));
  endfunction

  // One isolated access starting in an IDLE cycle; fixed LAT+1 cycle timeline.
  task automatic run_access(input vec_t v);
    if (v.is_dm) begin
      dm_req = 1'b1; dm_wr = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge clk);
      check({v.name, ":en"}, mem_enable, c == LAT);
      check({v.name, ":done"}, v.is_dm ? dm_done : if_done, c == LAT + 1);
      check({v.name, ":stall"}, v.is_dm ? dm_stall : if_stall, c <= LAT);
      if (c == LAT) begin
        check({v.name, ":addr"}, mem_addr, v.addr);
        check({v.name, ":wr"}, mem_wr, v.is_dm && v.wr);
        if (v.is_dm && v.wr)
          check({v.name, ":wdata"}, mem_data_in, v.wdata);
      end
      if (c == LAT + 1) begin
        check({v.name, ":rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
        if (v.is_dm && v.wr)
          check({v.name, ":memword"}, mem[v.addr], v.wdata);
      end
      tick();
    end
    dm_req = 1'b0;
    if_req = 1'b0;
  endtask

  initial begin : main
    bit          p_if, p_dm, f_if, f_dm, w_dm, last_dm, cand_if, cand_dm, prefer_dm;
    logic [15:0] a_if, a_dm, wd_dm, exp_if_rd, exp_dm_rd;
    int          idle_from, acc_if, acc_dm, done_if, done_dm;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "if_rd_0010"};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000, "dm_wr_0020"};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, "dm_rd_0020"};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'hA5A5, 16'h1234, "dm_wr_ffff"};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, "dm_rd_ffff"};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, "if_rd_ffff"};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1000, "dm_rd_0000"};
    vecs[7] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, "if_rd_0020"};

    rst = 1'b1; halt = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick();
    for (int i = 0; i < 8; i++) preload(16'(i), 16'h1000 + 16'(i));
    preload(16'h0010, 16'hBEEF);
    preload(16'h0020, 16'h0000);
    preload(16'h0050, 16'h1111);
    preload(16'hFFFF, 16'h0000);

    // Reset held 3 cycles with a pending fetch and halt: nothing reaches memory.
    if_req = 1'b1; if_addr = 16'h0010; halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst:en", mem_enable, 1'b0);
      check("rst:if_done", if_done, 1'b0);
      check("rst:if_rdata", if_rdata, 16'h0000);
      check("rst:dump", mem_createdump, 1'b0);
      tick();
    end
    rst = 1'b0; halt = 1'b0;

    for (int i = 0; i < 8; i++) run_access(vecs[i]);

    // Both ports request together: DM first, IF granted in DM's done cycle.
    if_req = 1'b1; if_addr = 16'h0010;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("conc:dm_done", dm_done, c == 3);
      check("conc:if_done", if_done, c == 6);
      check("conc:en", mem_enable, (c == 2) || (c == 5));
      if (c == 2) check("conc:dm_wr", mem_wr, 1'b1);
      if (c == 5) check("conc:if_addr", mem_addr, 16'h0010);
      if (c == 6) check("conc:if_rdata", if_rdata, 16'hBEEF);
      tick();
      if (c == 3) dm_req = 1'b0;
      if (c == 6) if_req = 1'b0;
    end

    // Reset one cycle into a DM write: the write and its done are abandoned.
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0050; dm_wdata = 16'hBBBB;
    @(negedge clk);
    check("rstmid:en0", mem_enable, 1'b0);
    tick();
    rst = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    check("rstmid:en1", mem_enable, 1'b0);
    tick();
    rst = 1'b0;
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      check("rstmid:en", mem_enable, 1'b0);
      check("rstmid:done", dm_done, 1'b0);
      tick();
    end
    check("rstmid:memword", mem[16'h0050], 16'h1111);
    check("rstmid:dm_rdata", dm_rdata, 16'h0000);
    check("rstmid:if_rdata", if_rdata, 16'h0000);

    // Halt raised while a fetch is in flight: dump waits for IDLE.
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    halt = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("halt:dump", mem_createdump, c >= 3);
      tick();
      if (c == 3) if_req = 1'b0;
    end
    halt = 1'b0;

    // Randomized traffic against a transaction-level model.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65536; i++) shadow[i] = mem[i];
    p_if = 0; p_dm = 0; f_if = 0; f_dm = 0; w_dm = 0; last_dm = 0;
    a_if = '0; a_dm = '0; wd_dm = '0; exp_if_rd = '0; exp_dm_rd = '0;
    idle_from = 0; acc_if = -1; acc_dm = -1; done_if = -1; done_dm = -1;
    for (int c = 0; c < NCYC; c++) begin
      if (!p_if && $urandom_range(0, 2) == 0) begin
        p_if = 1; a_if = rand_addr();
      end
      if (!p_dm && $urandom_range(0, 2) == 0) begin
        p_dm = 1; w_dm = 1'($urandom_range(0, 1)); a_dm = rand_addr(); wd_dm = 16'($urandom);
      end
      if_req = p_if; if_addr = a_if;
      dm_req = p_dm; dm_wr = w_dm; dm_addr = a_dm; dm_wdata = wd_dm;
      if (c >= idle_from) begin
        cand_if = p_if && !f_if;
        cand_dm = p_dm && !f_dm;
`ifdef ARB_ROUND_ROBIN_EN
        prefer_dm = !last_dm;
`else
        prefer_dm = 1'b1;
`endif
        if (cand_dm && (!cand_if || prefer_dm)) begin
          f_dm = 1; acc_dm = c + LAT; done_dm = c + LAT + 1; idle_from = c + LAT + 1;
          if (w_dm) shadow[a_dm] = wd_dm;
          else      exp_dm_rd = shadow[a_dm];
          last_dm = 1;
        end else if (cand_if) begin
          f_if = 1; acc_if = c + LAT; done_if = c + LAT + 1; idle_from = c + LAT + 1;
          exp_if_rd = shadow[a_if];
          last_dm = 0;
        end
      end
      @(negedge clk);
      check("rnd:if_done", if_done, c == done_if);
      check("rnd:dm_done", dm_done, c == done_dm);
      check("rnd:en", mem_enable, (c == acc_if) || (c == acc_dm));
      check("rnd:if_stall", if_stall, p_if && (c != done_if));
      check("rnd:dm_stall", dm_stall, p_dm && (c != done_dm));
      if (c == acc_if) check("rnd:if_addr", mem_addr, a_if);
      if (c == acc_dm) check("rnd:dm_addr", mem_addr, a_dm);
      if (c == done_if) begin
        check("rnd:if_rdata", if_rdata, exp_if_rd);
        p_if = 0; f_if = 0;
      end
      if (c == done_dm) begin
        check("rnd:dm_rdata", dm_rdata, exp_dm_rd);
        p_dm = 0; f_dm = 0;
      end
      tick();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (LAT + 3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the single-ported 16-bit word memory.
- Arbitrates between the instruction-fetch port (IF) and the data-memory port (DM).
- Stretches each access to a programmable multi-cycle latency and drives the memory's enable/wr/addr/data_in.
- Registers read data and returns per-port stall/done signals to the pipeline; the memory never sees concurrent read and write.

Parameters:
- LATENCY, 2, cycles spent in BUSY per access (legal 1..15); the memory access occurs in the last BUSY cycle.
- ADDR_W, 16, address width (word address).
- DATA_W, 16, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held high until if_done
- if_addr  in  ADDR_W  fetch address
- if_stall  out  1  fetch pending, not completing this cycle
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  fetched word, valid with if_done, held until next if_done
- dm_req  in  1  data request, held high until dm_done
- dm_wr  in  1  1=write, 0=read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_stall  out  1  data access pending, not completing
- dm_done  out  1  one-cycle completion pulse
- dm_rdata  out  DATA_W  read word, valid with dm_done, held until next read done
- halt  in  1  program halted; request a memory dump
- mem_enable  out  1  to memory enable
- mem_wr  out  1  to memory wr
- mem_addr  out  ADDR_W  to memory addr
- mem_data_in  out  DATA_W  to memory data_in
- mem_data_out  in  DATA_W  from memory data_out (combinational read)
- mem_createdump  out  1  to memory createdump

Behaviour:
- Reset: state IDLE, counter 0, all done/stall low, rdata regs 0, latched addr/data 0. mem_enable=0, mem_wr=0 and mem_createdump=0 while rst is high, so the memory's image load is undisturbed.
- Reset mid-access aborts it: no write is issued, no done pulse follows.
- States:
  - IDLE. DM has fixed priority. dm_req grants DM; else if_req grants IF.
  - At the grant edge: latch addr, wr and wdata; counter=LATENCY-1; go to BUSY_DM or BUSY_IF.
  - BUSY_x: counter decrements each cycle. When counter==0:
    - mem_enable=1 and mem_wr=latched wr (0 for IF); mem_addr and mem_data_in come from the latched values.
    - On a read, mem_data_out is captured into x_rdata at that edge.
    - Next state IDLE; x_done registered high for exactly the following cycle.
  - mem_enable=0 in all other cycles; mem_addr/mem_data_in are don't-care then and driven 0.
- Latency: request seen in IDLE at cycle T gives done in cycle T+LATENCY+1.
- Done-cycle rule: a port's req is ignored in the cycle its done is high, so a held req is not re-granted. The other port may be granted in that cycle.
- Stall: x_stall = x_req & ~x_done.
- A DM write leaves dm_rdata unchanged but still pulses dm_done.
- Dump: mem_createdump = halt & (state==IDLE) & ~rst. It never fires while an access is in flight.
- Addresses pass through unmodified; there is no alignment check or wrap logic. Address 16'hFFFF is legal.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
  - Defined: a 1-bit last-grant register (reset to IF) selects the port that did not win last when both request in IDLE. A single requester is always granted.
  - Undefined: DM fixed priority as above, and the last-grant register is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY_IF, BUSY_DM};
  - default LATENCY, ADDR_W and DATA_W constants;
  - port-id constants PORT_IF=0, PORT_DM=1.
- One sub-module, mem_lat_counter: a loadable down-counter with a zero flag (load, value, dec, zero).

Test Plan (LATENCY=2):
- Reset: assert rst 3 cycles with if_req=1 -> mem_enable=0, if_done=0, if_rdata=0 throughout; the first grant occurs the cycle after rst drops.
- IF read: mem[16'h0010]=16'hBEEF, if_req at cycle 5 -> mem_enable in cycle 7, if_done pulse in cycle 8 with if_rdata=16'hBEEF, if_stall high in cycles 5-7.
- Concurrent: if_req and dm_req (write 16'h1234 to 16'h0020) both at cycle 5 -> DM first (done at 8), IF granted at 8 (done at 11). With ARB_ROUND_ROBIN_EN and last grant=DM, IF goes first.
- Write then read: DM write 16'hA5A5 to 16'hFFFF, then DM read of 16'hFFFF -> dm_rdata=16'hA5A5; dm_rdata unchanged after the write's done.
- Reset mid-access: rst in cycle 6 of a DM write granted at 5 -> no mem_enable pulse, no dm_done, memory location unchanged.
- Halt: halt=1 while BUSY_IF -> mem_createdump stays 0 until state returns to IDLE, then goes 1.
